// File: rtl/seg_pkg.sv
// Shared seven-segment definitions: blank pattern, active-low hex glyphs, segment vector type.
package seg_pkg;

    typedef logic [6:0] seg_t;  // {G,F,E,D,C,B,A}, active-low

    localparam seg_t SEG_BLANK   = 7'h7F;
    localparam seg_t SEG_GLYPH_0 = 7'h40;
    localparam seg_t SEG_GLYPH_1 = 7'h79;
    localparam seg_t SEG_GLYPH_2 = 7'h24;
    localparam seg_t SEG_GLYPH_3 = 7'h30;
    localparam seg_t SEG_GLYPH_4 = 7'h19;
    localparam seg_t SEG_GLYPH_5 = 7'h12;
    localparam seg_t SEG_GLYPH_6 = 7'h02;
    localparam seg_t SEG_GLYPH_7 = 7'h78;
    localparam seg_t SEG_GLYPH_8 = 7'h00;
    localparam seg_t SEG_GLYPH_9 = 7'h10;
    localparam seg_t SEG_GLYPH_A = 7'h08;
    localparam seg_t SEG_GLYPH_B = 7'h03;
    localparam seg_t SEG_GLYPH_C = 7'h27;
    localparam seg_t SEG_GLYPH_D = 7'h21;
    localparam seg_t SEG_GLYPH_E = 7'h06;
    localparam seg_t SEG_GLYPH_F = 7'h0E;

endpackage

// File: rtl/seg_scan_driver_if.sv
// Host-side data/strobe and board-side display pins of the scan driver.
// Optional blink enables exist only when SEG_BLINK_EN is defined.
interface seg_scan_driver_if #(
    parameter int DIGITS = 4
);
    import seg_pkg::*;

    logic [4*DIGITS-1:0] num;
    logic [DIGITS-1:0]   dp;
    logic [DIGITS-1:0]   sel;
    logic                load;
`ifdef SEG_BLINK_EN
    logic [DIGITS-1:0]   blink;
`endif
    seg_t                seg;
    logic                seg_dp;
    logic [DIGITS-1:0]   an;
    logic                frame;

    modport slave (
        input  num, dp, sel, load,
`ifdef SEG_BLINK_EN
        input  blink,
`endif
        output seg, seg_dp, an, frame
    );

    modport master (
        output num, dp, sel, load,
`ifdef SEG_BLINK_EN
        output blink,
`endif
        input  seg, seg_dp, an, frame
    );

endinterface

// File: rtl/seg_hex_decode.sv
// Combinational nibble to active-low seven-segment glyph lookup; no latency, no flow control.
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] nib,
    output seg_t       glyph
);

    always_comb begin
        glyph = SEG_BLANK;
        case (nib)
            4'h0: glyph = SEG_GLYPH_0;
            4'h1: glyph = SEG_GLYPH_1;
            4'h2: glyph = SEG_GLYPH_2;
            4'h3: glyph = SEG_GLYPH_3;
            4'h4: glyph = SEG_GLYPH_4;
            4'h5: glyph = SEG_GLYPH_5;
            4'h6: glyph = SEG_GLYPH_6;
            4'h7: glyph = SEG_GLYPH_7;
            4'h8: glyph = SEG_GLYPH_8;
            4'h9: glyph = SEG_GLYPH_9;
            4'hA: glyph = SEG_GLYPH_A;
            4'hB: glyph = SEG_GLYPH_B;
            4'hC: glyph = SEG_GLYPH_C;
            4'hD: glyph = SEG_GLYPH_D;
            4'hE: glyph = SEG_GLYPH_E;
            4'hF: glyph = SEG_GLYPH_F;
            default: glyph = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed common-anode display scanner with frame-synchronous shadow data and anode dead time.
// Pins are registered one cycle after the scan state; loads are never back-pressured, they collapse per frame. Blink: SEG_BLINK_EN.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int DIGITS  = 4,
    parameter int DIV_W   = 16,
    parameter int DEAD    = 4
`ifdef SEG_BLINK_EN
    ,
    parameter int BLINK_W = 6
`endif
) (
    input  logic              new_clk,
    input  logic              rst,
    seg_scan_driver_if.slave  bus
);

    localparam int IDX_W = $clog2(DIGITS);

    logic [DIV_W-1:0]    presc;
    logic [IDX_W-1:0]    idx;
    logic                pending;
    logic [4*DIGITS-1:0] sh_num;
    logic [DIGITS-1:0]   sh_dp;
    logic [DIGITS-1:0]   sh_sel;
    logic                tick;
    logic                wrap;
    logic                dark;
    logic                lit;
    logic [3:0]          cur_nib;
    seg_t                glyph;

    assign tick    = &presc;
    assign wrap    = tick && (idx == IDX_W'(DIGITS - 1));
    assign cur_nib = sh_num[4*idx +: 4];

`ifdef SEG_BLINK_EN
    logic [BLINK_W-1:0] blink_cnt;
    logic [DIGITS-1:0]  sh_blink;

    always_ff @(posedge new_clk) begin
        if (rst) begin
            blink_cnt <= '0;
            sh_blink  <= '0;
        end else if (wrap) begin
            blink_cnt <= blink_cnt + 1'b1;
            if (pending || bus.load)
                sh_blink <= bus.blink;
        end
    end

    assign dark = blink_cnt[BLINK_W-1] & sh_blink[idx];
`else
    assign dark = 1'b0;
`endif

    assign lit = sh_sel[idx] & ~dark;

    seg_hex_decode u_dec (
        .nib   (cur_nib),
        .glyph (glyph)
    );

    // Shadow only moves at the wrap, so a frame never mixes old and new data.
    always_ff @(posedge new_clk) begin
        if (rst) begin
            presc   <= '0;
            idx     <= '0;
            pending <= 1'b0;
            sh_num  <= '0;
            sh_dp   <= '0;
            sh_sel  <= '0;
        end else begin
            presc <= presc + 1'b1;
            if (tick)
                idx <= wrap ? '0 : idx + 1'b1;
            if (wrap) begin
                if (pending || bus.load) begin
                    sh_num <= bus.num;
                    sh_dp  <= bus.dp;
                    sh_sel <= bus.sel;
                end
                pending <= 1'b0;
            end else if (bus.load) begin
                pending <= 1'b1;
            end
        end
    end

    always_ff @(posedge new_clk) begin
        if (rst) begin
            bus.seg    <= SEG_BLANK;
            bus.seg_dp <= 1'b1;
            bus.an     <= '1;
            bus.frame  <= 1'b0;
        end else begin
            bus.seg    <= lit ? glyph : SEG_BLANK;
            bus.seg_dp <= ~(lit & sh_dp[idx]);
            bus.an     <= (presc < DIV_W'(DEAD)) ? '1 : ~(DIGITS'(1) << idx);
            bus.frame  <= wrap;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Randomized and directed checks of seg_scan_driver against a cycle-count based reference model.
module tb_seg_scan_driver;
    import seg_pkg::*;

    localparam int DIGITS  = 4;
    localparam int DIV_W   = 4;
    localparam int DEAD    = 2;
    localparam int SLOT    = 1 << DIV_W;
    localparam int FRAME_C = SLOT * DIGITS;
`ifdef SEG_BLINK_EN
    localparam int BLINK_W = 2;
`endif

    logic new_clk = 1'b0;
    logic rst;

    seg_scan_driver_if #(.DIGITS(DIGITS)) bus ();

    seg_scan_driver #(
        .DIGITS (DIGITS),
        .DIV_W  (DIV_W),
        .DEAD   (DEAD)
`ifdef SEG_BLINK_EN
        ,
        .BLINK_W(BLINK_W)
`endif
    ) dut (
        .new_clk (new_clk),
        .rst     (rst),
        .bus     (bus)
    );

    always #5 new_clk = ~new_clk;

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference glyphs for hex digits 0..F, active-low.
    logic [6:0] glyph_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                   7'h00, 7'h10, 7'h08, 7'h03, 7'h27, 7'h21, 7'h06, 7'h0E};

    // Model state: cycles since the last reset edge plus the captured shadow.
    int          cyc;
    logic        m_pend;
    logic [15:0] m_num;
    logic [3:0]  m_dp;
    logic [3:0]  m_sel;
`ifdef SEG_BLINK_EN
    logic [3:0]  m_blink;
`endif

    task automatic step();
        logic [6:0] e_seg;
        logic       e_dp;
        logic [3:0] e_an;
        logic       e_frame;
        int         d;
        logic       on;
        @(posedge new_clk);
        if (rst) begin
            cyc = 0; m_pend = 1'b0; m_num = '0; m_dp = '0; m_sel = '0;
`ifdef SEG_BLINK_EN
            m_blink = '0;
`endif
            e_seg = 7'h7F; e_dp = 1'b1; e_an = 4'hF; e_frame = 1'b0;
        end else begin
            d  = (cyc / SLOT) % DIGITS;
            on = m_sel[d];
`ifdef SEG_BLINK_EN
            if (m_blink[d] && (((cyc / FRAME_C) >> (BLINK_W - 1)) & 1) == 1)
                on = 1'b0;
`endif
            e_seg   = on ? glyph_tab[m_num[4*d +: 4]] : 7'h7F;
            e_dp    = !(on && m_dp[d]);
            e_an    = ((cyc % SLOT) < DEAD) ? 4'hF : ~(4'(1) << d);
            e_frame = (cyc % FRAME_C) == FRAME_C - 1;
            if (e_frame) begin
                if (m_pend || bus.load) begin
                    m_num = bus.num; m_dp = bus.dp; m_sel = bus.sel;
`ifdef SEG_BLINK_EN
                    m_blink = bus.blink;
`endif
                end
                m_pend = 1'b0;
            end else if (bus.load) begin
                m_pend = 1'b1;
            end
            cyc++;
        end
        #1;
        check_val("seg",    32'(bus.seg),    32'(e_seg));
        check_val("seg_dp", 32'(bus.seg_dp), 32'(e_dp));
        check_val("an",     32'(bus.an),     32'(e_an));
        check_val("frame",  32'(bus.frame),  32'(e_frame));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pulse_load(input logic [15:0] n, input logic [3:0] p, input logic [3:0] s);
        bus.num = n; bus.dp = p; bus.sel = s; bus.load = 1'b1;
        step();
        bus.load = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.num = '0; bus.dp = '0; bus.sel = '0; bus.load = 1'b0;
`ifdef SEG_BLINK_EN
        bus.blink = 4'b0001;
`endif
        run(3);
        rst = 1'b0;
        run(70);

        pulse_load(16'h1234, 4'b1111, 4'b0100);
        bus.sel = 4'hF; bus.dp = 4'b0100;
        pulse_load(16'h1234, 4'b0100, 4'hF);
        run(140);

        pulse_load(16'hABCD, 4'h0, 4'hF);
        run(32);
        pulse_load(16'h0F0F, 4'h3, 4'hF);
        run(FRAME_C);

        // Load in exactly the wrap cycle.
        while ((cyc % FRAME_C) != FRAME_C - 1) step();
        pulse_load(16'h5555, 4'h0, 4'hF);
        run(FRAME_C + 2);

        pulse_load(16'h9876, 4'hA, 4'b0101);
        run(FRAME_C * 2);

        // Reset mid-slot with a load pending.
        while ((cyc % SLOT) != 7) step();
        pulse_load(16'hFFFF, 4'hF, 4'hF);
        rst = 1'b1;
        step();
        rst = 1'b0;
        run(FRAME_C + 5);

`ifdef SEG_BLINK_EN
        pulse_load(16'h8421, 4'h0, 4'hF);
        run(FRAME_C * 6);
`endif

        for (int i = 0; i < 1500; i++) begin
            bus.num  = 16'($urandom);
            bus.dp   = 4'($urandom);
            bus.sel  = 4'($urandom);
            bus.load = ($urandom_range(0, 39) == 0);
`ifdef SEG_BLINK_EN
            bus.blink = 4'($urandom);
`endif
            rst = ($urandom_range(0, 399) == 0);
            step();
        end
        rst = 1'b0; bus.load = 1'b0;
        run(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
